// File: rtl/pixel_dispatcher.sv
// rtl/pixel_dispatcher.sv - raster walker, lane launcher and round-robin result collector
module pixel_dispatcher #(
    parameter int NUM_LANES = 4,
    parameter int COORD_W   = 12,
    parameter int ITER_W    = 24
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          start,
    input  logic [COORD_W-1:0]            frame_width,
    input  logic [COORD_W-1:0]            frame_height,
    input  logic [ITER_W-1:0]             max_iterations_in,
    output logic                          busy,
    output logic                          frame_done,
    output logic [ITER_W-1:0]             max_iterations,
    output logic [NUM_LANES-1:0]          lane_clr,
    output logic [NUM_LANES*COORD_W-1:0]  lane_x,
    output logic [NUM_LANES*COORD_W-1:0]  lane_y,
    input  logic [NUM_LANES-1:0]          lane_done,
    input  logic [NUM_LANES*ITER_W-1:0]   lane_count,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [COORD_W-1:0]            m_x,
    output logic [COORD_W-1:0]            m_y,
    output logic [ITER_W-1:0]             m_count
);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {L_FREE, L_ARMED, L_BUSY, L_HOLD} lane_state_t;

    state_t             state;
    lane_state_t        lane_st [NUM_LANES];
    logic [LW-1:0]      rr;
    logic [COORD_W-1:0] width_q;
    logic [COORD_W-1:0] height_q;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;

    logic               free_found;
    logic [LW-1:0]      free_idx;
    logic               all_free;
    logic               grant_found;
    logic [LW-1:0]      grant_idx;
    logic               frame_zero;
    logic               launch;
    logic               last_pixel;
    logic               row_end;
    logic               out_load;
    logic [COORD_W-1:0] cur_x;
    logic [COORD_W-1:0] cur_y;
    logic [COORD_W-1:0] cur_w;
    logic [COORD_W-1:0] cur_h;

    // lowest-index free lane receives the next launch
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        all_free   = 1'b1;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_st[i] == L_FREE) begin
                free_found = 1'b1;
                free_idx   = LW'(i);
            end else begin
                all_free = 1'b0;
            end
        end
    end

    // round-robin pick among lanes holding a result, searching upward from rr
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_LANES) idx = idx - NUM_LANES;
            if (!grant_found && lane_st[idx] == L_HOLD) begin
                grant_found = 1'b1;
                grant_idx   = LW'(idx);
            end
        end
    end

    // launch decision; the accepting start edge already launches pixel (0,0) from the live inputs
    always_comb begin
        frame_zero = (frame_width == '0) || (frame_height == '0);
        cur_x      = (state == S_IDLE) ? '0 : pos_x;
        cur_y      = (state == S_IDLE) ? '0 : pos_y;
        cur_w      = (state == S_IDLE) ? frame_width : width_q;
        cur_h      = (state == S_IDLE) ? frame_height : height_q;
        launch     = free_found &&
                     ((state == S_RUN) || ((state == S_IDLE) && start && !frame_zero));
        row_end    = (cur_x == cur_w - COORD_W'(1));
        last_pixel = row_end && (cur_y == cur_h - COORD_W'(1));
        out_load   = !m_valid || m_ready;
    end

    // frame FSM, lane state machines, output register and launch registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            max_iterations <= '0;
            lane_clr       <= '0;
            lane_x         <= '0;
            lane_y         <= '0;
            m_valid        <= 1'b0;
            m_x            <= '0;
            m_y            <= '0;
            m_count        <= '0;
            rr             <= '0;
            width_q        <= '0;
            height_q       <= '0;
            pos_x          <= '0;
            pos_y          <= '0;
            for (int i = 0; i < NUM_LANES; i++) lane_st[i] <= L_FREE;
        end else begin
            lane_clr   <= '0;
            frame_done <= 1'b0;

            // ARMED ignores lane_done while the lane's old done level clears
            for (int i = 0; i < NUM_LANES; i++) begin
                case (lane_st[i])
                    L_ARMED: lane_st[i] <= L_BUSY;
                    L_BUSY:  if (lane_done[i]) lane_st[i] <= L_HOLD;
                    default: ;
                endcase
            end

            if (out_load) begin
                m_valid <= grant_found;
                if (grant_found) begin
                    m_x                <= lane_x[grant_idx*COORD_W +: COORD_W];
                    m_y                <= lane_y[grant_idx*COORD_W +: COORD_W];
                    m_count            <= lane_count[grant_idx*ITER_W +: ITER_W];
                    lane_st[grant_idx] <= L_FREE;
                    rr <= (int'(grant_idx) == NUM_LANES - 1) ? '0 : grant_idx + LW'(1);
                end
            end

            case (state)
                S_IDLE: if (start) begin
                    width_q        <= frame_width;
                    height_q       <= frame_height;
                    max_iterations <= max_iterations_in;
                    busy           <= 1'b1;
                    pos_x          <= '0;
                    pos_y          <= '0;
                    if (frame_zero) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end else if (launch && last_pixel) begin
                        state <= S_DRAIN;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: if (launch && last_pixel) state <= S_DRAIN;
                S_DRAIN: if (all_free && !m_valid) begin
                    state      <= S_DONE;
                    frame_done <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (launch) begin
                lane_st[free_idx]                      <= L_ARMED;
                lane_clr[free_idx]                     <= 1'b1;
                lane_x[free_idx*COORD_W +: COORD_W]    <= cur_x;
                lane_y[free_idx*COORD_W +: COORD_W]    <= cur_y;
                if (row_end) begin
                    pos_x <= '0;
                    pos_y <= cur_y + COORD_W'(1);
                end else begin
                    pos_x <= cur_x + COORD_W'(1);
                    pos_y <= cur_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb/tb_pixel_dispatcher.sv - directed self-checking bench for pixel_dispatcher
module tb_pixel_dispatcher;
    localparam int NL = 4;
    localparam int CW = 12;
    localparam int IW = 24;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     frame_width = '0;
    logic [CW-1:0]     frame_height = '0;
    logic [IW-1:0]     max_iterations_in = '0;
    logic              busy;
    logic              frame_done;
    logic [IW-1:0]     max_iterations;
    logic [NL-1:0]     lane_clr;
    logic [NL*CW-1:0]  lane_x;
    logic [NL*CW-1:0]  lane_y;
    logic [NL-1:0]     lane_done = '0;
    logic [NL*IW-1:0]  lane_count = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [CW-1:0]     m_x;
    logic [CW-1:0]     m_y;
    logic [IW-1:0]     m_count;

    pixel_dispatcher #(.NUM_LANES(NL), .COORD_W(CW), .ITER_W(IW)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .frame_width(frame_width), .frame_height(frame_height),
        .max_iterations_in(max_iterations_in), .busy(busy), .frame_done(frame_done),
        .max_iterations(max_iterations), .lane_clr(lane_clr), .lane_x(lane_x),
        .lane_y(lane_y), .lane_done(lane_done), .lane_count(lane_count),
        .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_count(m_count)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    int start_cyc = 0;
    int clr_rel[$], clr_lane[$], clr_x[$], clr_y[$];
    int res_rel[$], res_x[$], res_y[$], res_c[$];
    int fd_cnt, done_rel, valid_cnt, clr_cnt, reuse_err, stall_err, stall_cnt;
    logic          prev_stall = 1'b0;
    logic [CW-1:0] hx, hy;
    logic [IW-1:0] hc;
    int            cnt [NL];
    int            lat [NL];
    logic [NL-1:0] pending = '0;
    logic [CW-1:0] px [NL];
    logic [CW-1:0] py [NL];
    logic          model_rand = 1'b1;
    int            seen [9];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // monitor and lane model: sample mid-cycle, then update the modelled lanes
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_valid && m_ready) begin
                res_rel.push_back(cyc - start_cyc);
                res_x.push_back(int'(m_x));
                res_y.push_back(int'(m_y));
                res_c.push_back(int'(m_count));
                for (int i = 0; i < NL; i++)
                    if (pending[i] && px[i] == m_x && py[i] == m_y) pending[i] = 1'b0;
            end
            if (m_valid && !m_ready) begin
                stall_cnt++;
                if (prev_stall && (m_x !== hx || m_y !== hy || m_count !== hc)) stall_err++;
                hx = m_x; hy = m_y; hc = m_count;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (m_valid) valid_cnt++;
            if (frame_done) begin
                fd_cnt++;
                done_rel = cyc - start_cyc;
            end
            for (int i = 0; i < NL; i++) begin
                if (lane_clr[i]) begin
                    clr_rel.push_back(cyc - start_cyc);
                    clr_lane.push_back(i);
                    clr_x.push_back(int'(lane_x[i*CW +: CW]));
                    clr_y.push_back(int'(lane_y[i*CW +: CW]));
                    clr_cnt++;
                    if (pending[i]) reuse_err++;
                    pending[i] = 1'b1;
                    px[i] = lane_x[i*CW +: CW];
                    py[i] = lane_y[i*CW +: CW];
                end
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (model_rand) begin
                lane_done[i] = 1'($urandom_range(0, 1));
            end else if (!aresetn) begin
                lane_done[i] = 1'b0;
                cnt[i] = 0;
                pending[i] = 1'b0;
            end else if (lane_clr[i]) begin
                lane_done[i] = 1'b0;
                cnt[i] = lat[i];
                lane_count[i*IW +: IW] = IW'(lane_x[i*CW +: CW]) + IW'(lane_y[i*CW +: CW]) * 2;
            end else if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) lane_done[i] = 1'b1;
            end
        end
    end

    task automatic start_frame(input int w, input int h, input int mi);
        clr_rel.delete(); clr_lane.delete(); clr_x.delete(); clr_y.delete();
        res_rel.delete(); res_x.delete(); res_y.delete(); res_c.delete();
        fd_cnt = 0; done_rel = -1; valid_cnt = 0; clr_cnt = 0;
        stall_cnt = 0; stall_err = 0; reuse_err = 0;
        @(posedge aclk); #1;
        frame_width = CW'(w);
        frame_height = CW'(h);
        max_iterations_in = IW'(mi);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k;
        k = 0;
        while (fd_cnt == 0 && k < budget) begin
            @(negedge aclk);
            k++;
        end
        repeat (3) @(negedge aclk);
        chk(tag, 64'(fd_cnt), 64'd1);
    endtask

    task automatic check_2x2(input string tag);
        chk({tag, "_nclr"}, 64'(clr_rel.size()), 64'd4);
        chk({tag, "_nres"}, 64'(res_rel.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_clr_cyc"}, 64'(clr_rel[i]), 64'(i + 1));
            chk({tag, "_clr_lane"}, 64'(clr_lane[i]), 64'(i));
            chk({tag, "_clr_x"}, 64'(clr_x[i]), 64'(i % 2));
            chk({tag, "_clr_y"}, 64'(clr_y[i]), 64'(i / 2));
            chk({tag, "_res_cyc"}, 64'(res_rel[i]), 64'(9 + i));
            chk({tag, "_res_x"}, 64'(res_x[i]), 64'(i % 2));
            chk({tag, "_res_y"}, 64'(res_y[i]), 64'(i / 2));
            chk({tag, "_res_cnt"}, 64'(res_c[i]), 64'(i));
        end
        chk({tag, "_done_cyc"}, 64'(done_rel), 64'd14);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int ex_x [4];
        int ex_y [4];
        int ex_c [4];
        for (int i = 0; i < NL; i++) lat[i] = 6;

        // reset with random inputs
        for (int c = 0; c < 3; c++) begin
            @(posedge aclk); #1;
            start = 1'($urandom_range(0, 1));
            frame_width = CW'($urandom);
            frame_height = CW'($urandom);
            max_iterations_in = IW'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            chk("rst_lane_clr", 64'(lane_clr), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
        end
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_max_it", 64'(max_iterations), 64'd0);
        chk("rst_lane_xy", 64'(lane_x | lane_y), 64'd0);
        chk("rst_m_data", 64'({m_x, m_y, m_count}), 64'd0);
        @(posedge aclk); #1;
        model_rand = 1'b0;
        start = 1'b0;
        m_ready = 1'b1;
        clr_cnt = 0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_no_clr", 64'(clr_cnt), 64'd0);

        // 2x2 frame
        start_frame(2, 2, 'h1234);
        @(negedge aclk);
        chk("f2x2_busy_c1", 64'(busy), 64'd1);
        chk("f2x2_clr_c1", 64'(lane_clr), 64'd1);
        wait_done(100, "f2x2_frame_done");
        check_2x2("f2x2");
        chk("f2x2_max_it", 64'(max_iterations), 64'h1234);

        // 2x1 frame leaves rr at 2, then all four lanes finish together
        start_frame(2, 1, 5);
        wait_done(100, "f2x1_frame_done");
        chk("f2x1_nres", 64'(res_rel.size()), 64'd2);
        lat[0] = 9; lat[1] = 8; lat[2] = 7; lat[3] = 6;
        start_frame(2, 2, 5);
        wait_done(100, "simul_frame_done");
        ex_x = '{0, 1, 0, 1};
        ex_y = '{1, 1, 0, 0};
        ex_c = '{2, 3, 0, 1};
        chk("simul_nres", 64'(res_rel.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("simul_cyc", 64'(res_rel[i]), 64'(12 + i));
            chk("simul_x", 64'(res_x[i]), 64'(ex_x[i]));
            chk("simul_y", 64'(res_y[i]), 64'(ex_y[i]));
            chk("simul_cnt", 64'(res_c[i]), 64'(ex_c[i]));
        end

        // backpressure on a 4x1 frame
        for (int i = 0; i < NL; i++) lat[i] = 6;
        @(posedge aclk); #1;
        m_ready = 1'b0;
        start_frame(4, 1, 9);
        repeat (19) begin
            @(posedge aclk); #1;
        end
        m_ready = 1'b1;
        wait_done(100, "bp_frame_done");
        chk("bp_stall_cycles", 64'(stall_cnt), 64'd11);
        chk("bp_stall_stable", 64'(stall_err), 64'd0);
        chk("bp_nres", 64'(res_rel.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_cyc", 64'(res_rel[i]), 64'(20 + i));
            chk("bp_x", 64'(res_x[i]), 64'(i));
            chk("bp_cnt", 64'(res_c[i]), 64'(i));
        end

        // zero-width frame
        start_frame(0, 3, 7);
        @(negedge aclk);
        chk("zero_busy_c1", 64'(busy), 64'd1);
        chk("zero_done_c1", 64'(frame_done), 64'd1);
        @(negedge aclk);
        chk("zero_busy_c2", 64'(busy), 64'd0);
        chk("zero_done_c2", 64'(frame_done), 64'd0);
        wait_done(20, "zero_frame_done");
        chk("zero_no_clr", 64'(clr_cnt), 64'd0);
        chk("zero_no_valid", 64'(valid_cnt), 64'd0);
        chk("zero_done_cyc", 64'(done_rel), 64'd1);
        chk("zero_max_it", 64'(max_iterations), 64'd7);

        // 3x3 frame with lane reuse and an ignored mid-frame start
        lat[0] = 6; lat[1] = 3; lat[2] = 5; lat[3] = 4;
        start_frame(3, 3, 100);
        repeat (2) begin
            @(posedge aclk); #1;
        end
        start = 1'b1;
        frame_width = 1;
        frame_height = 1;
        max_iterations_in = 7;
        @(posedge aclk); #1;
        start = 1'b0;
        wait_done(400, "f3x3_frame_done");
        chk("f3x3_nres", 64'(res_rel.size()), 64'd9);
        chk("f3x3_reuse", 64'(reuse_err), 64'd0);
        chk("f3x3_max_it", 64'(max_iterations), 64'd100);
        for (int p = 0; p < 9; p++) seen[p] = 0;
        for (int j = 0; j < res_rel.size(); j++) begin
            if (res_x[j] < 3 && res_y[j] < 3) seen[res_y[j] * 3 + res_x[j]]++;
            chk("f3x3_cnt", 64'(res_c[j]), 64'(res_x[j] + 2 * res_y[j]));
        end
        for (int p = 0; p < 9; p++) chk("f3x3_pixel_once", 64'(seen[p]), 64'd1);

        // reset in the middle of a frame, then a fresh frame
        for (int i = 0; i < NL; i++) lat[i] = 6;
        start_frame(2, 2, 'h55);
        repeat (3) begin
            @(posedge aclk); #1;
        end
        aresetn = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_lane_clr", 64'(lane_clr), 64'd0);
        chk("mrst_m_valid", 64'(m_valid), 64'd0);
        chk("mrst_lane_xy", 64'(lane_x | lane_y), 64'd0);
        chk("mrst_max_it", 64'(max_iterations), 64'd0);
        chk("mrst_m_data", 64'({m_x, m_y, m_count}), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        chk("mrst_idle_busy", 64'(busy), 64'd0);
        start_frame(2, 2, 'h66);
        wait_done(100, "mrst_frame_done");
        check_2x2("mrst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
